pass2_scheduler: RTL and testbench
==================================

// Module: pass2_scheduler
// PURPOSE
//  Shares one hash padder plus second-pass SHA-256 core among NUM_REQ first-pass cores.
//  - Round-robin arbitrates pending first-pass digests.
//  - Loads the winner's digest into the padder and counts the 16 padded words into the core.
//  - Waits for the core to finish, then returns the final digest tagged with the requester index.
// PARAMETERS
//  NUM_REQ   4    number of requesting first-pass cores (2..16)
//  IDX_W     2    requester index width, = $clog2(NUM_REQ)
// PORTS
//  clk            in   1            system clock, rising edge
//  rst_n          in   1            asynchronous active-low reset
//  req_i          in   NUM_REQ      requester r holds hash_i[r] valid while high
//  hash_i         in   NUM_REQ*256  first-pass digests, HashState per requester
//  gnt_o          out  NUM_REQ      one-hot, 1-cycle pulse: digest r accepted
//  pad_start_o    out  1            padder start; pad_hash_o sampled the same cycle
//  pad_hash_o     out  256          selected digest to padder
//  word_valid_o   out  1            padder word_o is padded word word_idx_o this cycle
//  word_idx_o     out  4            padded word index 0..15 to core
//  core_done_i    in   1            core finished compression (1-cycle pulse)
//  core_digest_i  in   256          final digest, valid with core_done_i
//  res_valid_o    out  1            1-cycle pulse: res_digest_o/res_idx_o valid
//  res_digest_o   out  256          registered final digest
//  res_idx_o      out  IDX_W        requester that owns res_digest_o
//  busy_o         out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; all outputs 0 (pad_hash_o, res_digest_o = 0).
//  FSM IDLE -> LOAD -> STREAM -> WAIT -> IDLE.
//  IDLE: if |req_i, pick first set bit at or after rr_ptr (wrap at NUM_REQ-1 -> 0).
//   - Register the winner index; go to LOAD. Otherwise stay.
//  LOAD (1 cycle):
//   - pad_start_o=1, pad_hash_o=hash_i[win], gnt_o[win]=1.
//   - rr_ptr <= win+1 (mod NUM_REQ); cnt <= 0; go to STREAM.
//  STREAM: word_valid_o=1 for exactly 16 consecutive cycles, word_idx_o=cnt=0..15.
//   - First STREAM cycle is the cycle after pad_start_o; no stall, no gaps.
//   - After cnt==15, go to WAIT.
//  WAIT: hold until core_done_i.
//   - Capture core_digest_i into res_digest_o and win into res_idx_o.
//   - res_valid_o=1 the next cycle (IDLE); then 0.
//  core_done_i outside WAIT is ignored; no result is produced for it.
//  Requester may drop req_i before LOAD: the grant still issues to the registered winner.
//   - The digest sampled in LOAD is used as-is.
//  Requester may hold req_i after gnt_o; it is treated as a new request (re-arbitrated).
//  pad_hash_o holds its last value outside LOAD; padder samples only on pad_start_o.
//  Only one job in flight; req_i is ignored while busy_o=1.
//  New arbitration may occur in the same cycle res_valid_o is high (IDLE with pending req).
//  rst_n low mid-job: immediately IDLE, outputs 0, in-flight job discarded, no res_valid_o.
//   - Requesters must re-request.
//  Job latency: req seen in IDLE at cycle t -> gnt_o t+1 -> words t+2..t+17 -> WAIT from t+18.
// TESTING
//  1. Reset, req_i=4'b0100, hash_i[2]=0xA5..A5 -> gnt_o=4'b0100 one cycle; pad_hash_o=0xA5..A5.
//     Then 16 word_valid_o cycles, idx 0..15.
//  2. Scenario 1 then core_done_i with core_digest_i=0x1234.. in WAIT
//     -> next cycle res_valid_o=1, res_idx_o=2, res_digest_o=0x1234..
//  3. req_i=4'b1111 held, done returned each job -> grants in order 0,1,2,3,0; no repeats.
//  4. req_i=4'b1001 with rr_ptr=1 -> grant 3, then 0; a req_i pulse during STREAM is not granted.
//  5. rst_n low at word_idx_o=7 -> all outputs 0 immediately; a later core_done_i gives no result.
//  6. core_done_i pulsed in IDLE and in STREAM -> no res_valid_o; word count unaffected.

Source files
------------

// File: rtl/pass2_scheduler.sv
// Shares one padder and second-pass SHA-256 core among NUM_REQ first-pass cores:
// round-robin pick, load digest into padder, stream 16 word indices, return tagged result.
module pass2_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  localparam int unsigned HASH_W = 256,
  localparam int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*HASH_W-1:0] hash_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      pad_start_o,
  output logic [HASH_W-1:0]         pad_hash_o,
  output logic                      word_valid_o,
  output logic [CNT_W-1:0]          word_idx_o,
  input  logic                      core_done_i,
  input  logic [HASH_W-1:0]         core_digest_i,
  output logic                      res_valid_o,
  output logic [HASH_W-1:0]         res_digest_o,
  output logic [IDX_W-1:0]          res_idx_o,
  output logic                      busy_o
);

  localparam int unsigned WORDS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    WAIT   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 pad_start_q, pad_start_d;
  logic [HASH_W-1:0]    pad_hash_q, pad_hash_d;
  logic                 word_valid_q, word_valid_d;
  logic [CNT_W-1:0]     word_idx_q, word_idx_d;
  logic                 res_valid_q, res_valid_d;
  logic [HASH_W-1:0]    res_digest_q, res_digest_d;
  logic [IDX_W-1:0]     res_idx_q, res_idx_d;
  logic                 busy_q, busy_d;

  logic                 found_c;
  logic [IDX_W-1:0]     pick_c;
  logic [HASH_W-1:0]    hash_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign hash_arr[g] = hash_i[g*HASH_W +: HASH_W];
  end

  // Round-robin: first set request at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    found_c  = 1'b0;
    pick_c   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found_c && req_i[cand_idx]) begin
        found_c = 1'b1;
        pick_c  = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_q        <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      pad_start_q  <= 1'b0;
      pad_hash_q   <= '0;
      word_valid_q <= 1'b0;
      word_idx_q   <= '0;
      res_valid_q  <= 1'b0;
      res_digest_q <= '0;
      res_idx_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      pad_start_q  <= pad_start_d;
      pad_hash_q   <= pad_hash_d;
      word_valid_q <= word_valid_d;
      word_idx_q   <= word_idx_d;
      res_valid_q  <= res_valid_d;
      res_digest_q <= res_digest_d;
      res_idx_q    <= res_idx_d;
      busy_q       <= busy_d;
    end
  end

  // Outputs are computed one cycle ahead so each registered output lines up with its state.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    pad_start_d  = 1'b0;
    pad_hash_d   = pad_hash_q;
    word_valid_d = 1'b0;
    word_idx_d   = '0;
    res_valid_d  = 1'b0;
    res_digest_d = res_digest_q;
    res_idx_d    = res_idx_q;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          win_d       = pick_c;
          gnt_d       = NUM_REQ'(1) << pick_c;
          pad_start_d = 1'b1;
          pad_hash_d  = hash_arr[pick_c];
          state_d     = LOAD;
        end
      end
      LOAD: begin
        rr_ptr_d     = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);
        cnt_d        = '0;
        word_valid_d = 1'b1;
        word_idx_d   = '0;
        state_d      = STREAM;
      end
      STREAM: begin
        if (cnt_q == CNT_W'(WORDS - 1)) begin
          state_d = WAIT;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          word_valid_d = 1'b1;
          word_idx_d   = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (core_done_i) begin
          res_valid_d  = 1'b1;
          res_digest_d = core_digest_i;
          res_idx_d    = win_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt_o        = gnt_q;
  assign pad_start_o  = pad_start_q;
  assign pad_hash_o   = pad_hash_q;
  assign word_valid_o = word_valid_q;
  assign word_idx_o   = word_idx_q;
  assign res_valid_o  = res_valid_q;
  assign res_digest_o = res_digest_q;
  assign res_idx_o    = res_idx_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pass2_scheduler.sv
// Bench for pass2_scheduler: directed scenarios plus randomized jobs against a job-level model.
module tb_pass2_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ*256-1:0] hash_i;
  logic [NUM_REQ-1:0]     gnt_o;
  logic                   pad_start_o;
  logic [255:0]           pad_hash_o;
  logic                   word_valid_o;
  logic [3:0]             word_idx_o;
  logic                   core_done_i;
  logic [255:0]           core_digest_i;
  logic                   res_valid_o;
  logic [255:0]           res_digest_o;
  logic [IDX_W-1:0]       res_idx_o;
  logic                   busy_o;

  logic [255:0] hash_arr [NUM_REQ];
  int n_checks;
  int n_errors;
  int model_rr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign hash_i[g*256 +: 256] = hash_arr[g];
  end

  pass2_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .hash_i        (hash_i),
    .gnt_o         (gnt_o),
    .pad_start_o   (pad_start_o),
    .pad_hash_o    (pad_hash_o),
    .word_valid_o  (word_valid_o),
    .word_idx_o    (word_idx_o),
    .core_done_i   (core_done_i),
    .core_digest_i (core_digest_i),
    .res_valid_o   (res_valid_o),
    .res_digest_o  (res_digest_o),
    .res_idx_o     (res_idx_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Job-level model: first requester at or after the pointer, pointer moves past the winner.
  function automatic int model_pick(input logic [NUM_REQ-1:0] req);
    logic [NUM_REQ-1:0] rq;
    rq = req;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (model_rr + i) % NUM_REQ;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   256'(gnt_o), '0);
    check({tag, "_pst"},   256'(pad_start_o), '0);
    check({tag, "_phash"}, pad_hash_o, '0);
    check({tag, "_wv"},    256'(word_valid_o), '0);
    check({tag, "_widx"},  256'(word_idx_o), '0);
    check({tag, "_rv"},    256'(res_valid_o), '0);
    check({tag, "_rdig"},  res_digest_o, '0);
    check({tag, "_ridx"},  256'(res_idx_o), '0);
    check({tag, "_busy"},  256'(busy_o), '0);
  endtask

  // Runs one job starting at a negedge in IDLE; ends at the negedge showing res_valid_o.
  task automatic run_job(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] stream_req,
                         input bit done_in_stream, input int rst_at, input logic [255:0] dig,
                         output int win);
    logic [255:0] sampled;
    int           waits;
    win = model_pick(req);
    req_i = req;
    @(negedge clk);
    sampled = hash_arr[win];
    check("load_gnt",   256'(gnt_o), 256'(1) << win);
    check("load_pst",   256'(pad_start_o), 256'(1));
    check("load_phash", pad_hash_o, sampled);
    check("load_busy",  256'(busy_o), 256'(1));
    model_rr = (win + 1) % NUM_REQ;
    req_i = stream_req;
    hash_arr[win] = rand256();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) req_i = '0;
      check("str_wv",   256'(word_valid_o), 256'(1));
      check("str_widx", 256'(word_idx_o), 256'(k));
      check("str_gnt",  256'(gnt_o), '0);
      check("str_rv",   256'(res_valid_o), '0);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_rr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      core_done_i = (done_in_stream && k == 5);
      if (core_done_i) core_digest_i = rand256();
    end
    core_done_i = 1'b0;
    @(negedge clk);
    check("wait_wv",    256'(word_valid_o), '0);
    check("wait_busy",  256'(busy_o), 256'(1));
    check("wait_phash", pad_hash_o, sampled);
    waits = $urandom_range(0, 3);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check("wait_rv", 256'(res_valid_o), '0);
    end
    core_done_i   = 1'b1;
    core_digest_i = dig;
    @(negedge clk);
    core_done_i   = 1'b0;
    core_digest_i = rand256();
    check("res_valid", 256'(res_valid_o), 256'(1));
    check("res_idx",   256'(res_idx_o), 256'(win));
    check("res_dig",   res_digest_o, dig);
    check("res_busy",  256'(busy_o), '0);
    req_i = '0;
  endtask

  initial begin
    int win;
    n_checks = 0;
    n_errors = 0;
    model_rr = 0;
    rst_n = 1'b0;
    req_i = '0;
    core_done_i = 1'b0;
    core_digest_i = '0;
    for (int r = 0; r < NUM_REQ; r++) hash_arr[r] = rand256();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 2 with a known digest and known core result.
    hash_arr[2] = {32{8'hA5}};
    run_job(4'b0100, 4'b0000, 1'b0, -1, {16{16'h1234}}, win);
    check("t1_win", 256'(win), 256'(2));

    // All requesting: strict rotation starting from the pointer past 2 -> 3,0,1,2,3.
    for (int j = 0; j < 5; j++) begin
      run_job(4'b1111, 4'b0000, 1'b0, -1, rand256(), win);
      check("t3_order", 256'(win), 256'((3 + j) % 4));
    end

    // Pointer now at 0; run 0 to put it at 1, then 1001 -> 3 then 0, with a ignored pulse.
    run_job(4'b0001, 4'b0000, 1'b0, -1, rand256(), win);
    run_job(4'b1001, 4'b0010, 1'b0, -1, rand256(), win);
    check("t4_first", 256'(win), 256'(3));
    run_job(4'b1001, 4'b0000, 1'b1, -1, rand256(), win);
    check("t4_second", 256'(win), 256'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_nognt",  256'(gnt_o), '0);
      check("t4_idle",   256'(busy_o), '0);
    end

    // Stray done while idle produces no result.
    core_done_i = 1'b1;
    @(negedge clk);
    core_done_i = 1'b0;
    check("idle_done_rv", 256'(res_valid_o), '0);
    @(negedge clk);
    check("idle_done_rv2", 256'(res_valid_o), '0);

    // Reset mid-stream, then a late done must not surface a result.
    run_job(4'b0010, 4'b0000, 1'b0, 7, rand256(), win);
    core_done_i = 1'b1;
    @(negedge clk);
    core_done_i = 1'b0;
    check("post_rst_rv", 256'(res_valid_o), '0);
    check("post_rst_busy", 256'(busy_o), '0);
    @(negedge clk);
    check("post_rst_rv2", 256'(res_valid_o), '0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      for (int r = 0; r < NUM_REQ; r++) hash_arr[r] = rand256();
      run_job(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              -1, rand256(), win);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rnd_gap_rv", 256'(res_valid_o), '0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
